// File: rtl/ensemble_vote_combiner_pkg.sv
// Shared constants for the ensemble vote combiner: label width, agreement
// codes and the stream slot assigned to each classifier.
package ensemble_pkg;
  localparam int CLASS_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    AGREE_NONE = 2'd0,
    AGREE_TIE  = 2'd1,
    AGREE_MAJ  = 2'd2,
    AGREE_UNAN = 2'd3
  } agree_e;

  localparam int STRM_GNB = 0;
  localparam int STRM_GB  = 1;
  localparam int STRM_MLP = 2;
  localparam int NUM_IN   = 3;
endpackage

// File: rtl/ensemble_vote_combiner_if.sv
// AXI-Stream bundle used for the three classifier inputs and the vote output.
interface ensemble_axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ensemble_vote_combiner_fifo.sv
// Synchronous FIFO holding {label, tlast}; ready is registered so it stays
// low through reset and drops the cycle after the filling write.
module vote_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt_nx;
  logic             wr, rd;

  assign wr    = push && ready;
  assign rd    = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rp];

  always_comb begin
    cnt_nx = count;
    if (wr && !rd)      cnt_nx = count + CW'(1);
    else if (rd && !wr) cnt_nx = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count <= cnt_nx;
      ready <= (cnt_nx != CW'(DEPTH));
    end
  end
endmodule

// File: rtl/ensemble_vote_combiner.sv
// Aligns three classifier result streams in per-input FIFOs and emits one
// majority-vote label per sample, with vote/disagreement counters.
module ensemble_vote_combiner
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = CLASS_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIE_SEL     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ensemble_axis_if.slave         s_axis_1,
  ensemble_axis_if.slave         s_axis_2,
  ensemble_axis_if.slave         s_axis_3,
  ensemble_axis_if.master        m_axis,
  output logic                   tlast_mismatch,
  output logic [31:0]            vote_count,
  output logic [31:0]            disagree_count
);
  localparam int EW    = CLASS_WIDTH + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_IN-1:0]                  push, rdy, full, empty, lst;
  logic [NUM_IN-1:0][EW-1:0]          din, dout;
  logic [NUM_IN-1:0][CNT_W-1:0]       count;
  logic [NUM_IN-1:0][CLASS_WIDTH-1:0] lab;
  logic                               pop, xfer;
  agree_e                             code;
  logic [CLASS_WIDTH-1:0]             win;
  logic [DATA_WIDTH-1:0]              vote_data;

  assign push[STRM_GNB] = s_axis_1.tvalid;
  assign push[STRM_GB]  = s_axis_2.tvalid;
  assign push[STRM_MLP] = s_axis_3.tvalid;
  assign din[STRM_GNB]  = {s_axis_1.tdata[CLASS_WIDTH-1:0], s_axis_1.tlast};
  assign din[STRM_GB]   = {s_axis_2.tdata[CLASS_WIDTH-1:0], s_axis_2.tlast};
  assign din[STRM_MLP]  = {s_axis_3.tdata[CLASS_WIDTH-1:0], s_axis_3.tlast};
  assign s_axis_1.tready = rdy[STRM_GNB];
  assign s_axis_2.tready = rdy[STRM_GB];
  assign s_axis_3.tready = rdy[STRM_MLP];

  // All three FIFOs pop in lockstep so entries stay sample-aligned.
  assign pop  = ~|empty && (!m_axis.tvalid || m_axis.tready);
  assign xfer = m_axis.tvalid && m_axis.tready;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_fifo
    vote_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .din   (din[k]),
      .ready (rdy[k]),
      .pop   (pop),
      .dout  (dout[k]),
      .full  (full[k]),
      .empty (empty[k]),
      .count (count[k])
    );
    assign lab[k] = dout[k][EW-1:1];
    assign lst[k] = dout[k][0];
  end

  always_comb begin
    win  = lab[TIE_SEL];
    code = AGREE_TIE;
    if (lab[0] == lab[1] && lab[1] == lab[2]) begin
      win  = lab[0];
      code = AGREE_UNAN;
    end else if (lab[0] == lab[1] || lab[0] == lab[2]) begin
      win  = lab[0];
      code = AGREE_MAJ;
    end else if (lab[1] == lab[2]) begin
      win  = lab[1];
      code = AGREE_MAJ;
    end
    vote_data = '0;
    vote_data[CLASS_WIDTH-1:0]           = win;
    vote_data[CLASS_WIDTH+1:CLASS_WIDTH] = code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.tvalid  <= 1'b0;
      m_axis.tdata   <= '0;
      m_axis.tkeep   <= '0;
      m_axis.tlast   <= 1'b0;
      tlast_mismatch <= 1'b0;
      vote_count     <= '0;
      disagree_count <= '0;
    end else begin
      if (pop) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= vote_data;
        m_axis.tkeep  <= '1;
        m_axis.tlast  <= lst[STRM_GNB];
        if (!(&lst) && (|lst)) tlast_mismatch <= 1'b1;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
      if (xfer) begin
        vote_count <= vote_count + 32'd1;
        if (m_axis.tdata[CLASS_WIDTH+1:CLASS_WIDTH] != AGREE_UNAN)
          disagree_count <= disagree_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Directed bench for ensemble_vote_combiner: vector table plus multi-cycle
// sequences for skewed inputs, output stall, tlast mismatch and mid-run reset.
module tb_ensemble_vote_combiner;
  import ensemble_pkg::*;

  typedef struct {
    logic [7:0]  a, b, c;
    logic        tl;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] td  [3];
  logic        tv  [3];
  logic        tlv [3];
  logic        rdy [3];
  logic        m_tready;
  logic        tlast_mismatch;
  logic [31:0] vote_count, disagree_count;

  int          checks = 0, failures = 0, cyc = 0;
  logic [7:0]  lab [3][8];
  logic        ltl [3][8];
  logic [10:0] got [$];
  int          got_t [$];
  vec_t        vecs [7];
  logic [10:0] exp2 [4];
  logic [10:0] exp3 [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ensemble_axis_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s1 (), s2 (), s3 (), m ();

  assign s1.tdata = td[0];  assign s1.tvalid = tv[0];  assign s1.tlast = tlv[0];  assign s1.tkeep = '0;
  assign s2.tdata = td[1];  assign s2.tvalid = tv[1];  assign s2.tlast = tlv[1];  assign s2.tkeep = '0;
  assign s3.tdata = td[2];  assign s3.tvalid = tv[2];  assign s3.tlast = tlv[2];  assign s3.tkeep = '0;
  assign rdy[0] = s1.tready;
  assign rdy[1] = s2.tready;
  assign rdy[2] = s3.tready;
  assign m.tready = m_tready;

  ensemble_vote_combiner #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .CLASS_WIDTH(8), .FIFO_DEPTH(4), .TIE_SEL(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_1       (s1),
    .s_axis_2       (s2),
    .s_axis_3       (s3),
    .m_axis         (m),
    .tlast_mismatch (tlast_mismatch),
    .vote_count     (vote_count),
    .disagree_count (disagree_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        lab[k][i] = 8'(base + i);
        ltl[k][i] = 1'b0;
      end
  endtask

  // Call at a negedge; holds valid until n beats are handshaken.
  task automatic drive(input int k, input int n, input int pre);
    int sent = 0;
    int waited = 0;
    repeat (pre) @(negedge clk);
    while (sent < n && waited < 200) begin
      tv[k]  = 1'b1;
      td[k]  = {24'h5A5A5A, lab[k][sent]};
      tlv[k] = ltl[k][sent];
      if (rdy[k]) sent++;
      @(negedge clk);
      waited++;
    end
    tv[k]  = 1'b0;
    tlv[k] = 1'b0;
    check($sformatf("drive%0d_beats", k), 64'(sent), 64'(n));
  endtask

  task automatic collect(input int n, input int budget);
    int waited = 0;
    got.delete();
    got_t.delete();
    while (got.size() < n && waited < budget) begin
      if (m.tvalid && m_tready) begin
        got.push_back({m.tlast, m.tdata[9:0]});
        got_t.push_back(cyc);
      end
      @(negedge clk);
      waited++;
    end
    check("collect_count", 64'(got.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dis;
    int stale;
    for (int k = 0; k < 3; k++) begin
      tv[k] = 1'b0; td[k] = '0; tlv[k] = 1'b0;
    end
    m_tready = 1'b1;

    vecs[0] = '{8'h05, 8'h05, 8'h05, 1'b0, 32'h305};
    vecs[1] = '{8'h02, 8'h07, 8'h02, 1'b0, 32'h202};
    vecs[2] = '{8'h01, 8'h04, 8'h09, 1'b1, 32'h109};
    vecs[3] = '{8'h03, 8'h03, 8'h08, 1'b0, 32'h203};
    vecs[4] = '{8'h06, 8'h09, 8'h09, 1'b0, 32'h209};
    vecs[5] = '{8'h04, 8'h01, 8'h04, 1'b0, 32'h204};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 32'h3FF};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tready", {rdy[0], rdy[1], rdy[2]}, 3'b000);
    check("rst_tvalid", m.tvalid, 1'b0);
    check("rst_tdata", m.tdata, 32'h0);
    check("rst_tkeep", m.tkeep, 4'h0);
    check("rst_tlast", m.tlast, 1'b0);
    check("rst_counts", {vote_count, disagree_count}, 64'h0);
    check("rst_mismatch", tlast_mismatch, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_release", {rdy[0], rdy[1], rdy[2]}, 3'b111);

    // Vector table: all three beats in one cycle, output ready
    dis = 0;
    for (int i = 0; i < 7; i++) begin
      td[0] = {24'hA5A5A5, vecs[i].a};
      td[1] = {24'hA5A5A5, vecs[i].b};
      td[2] = {24'hA5A5A5, vecs[i].c};
      for (int k = 0; k < 3; k++) begin tv[k] = 1'b1; tlv[k] = vecs[i].tl; end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin tv[k] = 1'b0; tlv[k] = 1'b0; end
      check($sformatf("v%0d_not_yet_valid", i), m.tvalid, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), m.tvalid, 1'b1);
      check($sformatf("v%0d_tdata", i), m.tdata, vecs[i].exp);
      check($sformatf("v%0d_tlast", i), m.tlast, vecs[i].tl);
      check($sformatf("v%0d_tkeep", i), m.tkeep, 4'hF);
      if (vecs[i].exp[9:8] != 2'd3) dis++;
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), m.tvalid, 1'b0);
      check($sformatf("v%0d_vote_count", i), vote_count, 32'(i + 1));
      check($sformatf("v%0d_disagree", i), disagree_count, 32'(dis));
    end
    check("mismatch_still_clear", tlast_mismatch, 1'b0);

    // Stream 3 lags; streams 1/2 fill their FIFOs; sample 3 has tlast mismatch
    fill(10);
    lab[2][1] = 8'd20; lab[2][3] = 8'd30;
    ltl[0][2] = 1'b1;  ltl[1][2] = 1'b1;
    exp2 = '{11'h30A, 11'h20B, 11'h70C, 11'h20D};
    fork
      drive(0, 4, 0);
      drive(1, 4, 0);
    join
    check("skew_tready1_low", rdy[0], 1'b0);
    check("skew_tready2_low", rdy[1], 1'b0);
    check("skew_tready3_high", rdy[2], 1'b1);
    check("skew_no_vote", m.tvalid, 1'b0);
    repeat (10) @(negedge clk);
    check("skew_no_vote_late", m.tvalid, 1'b0);
    fork
      drive(2, 4, 0);
      collect(4, 40);
    join
    for (int i = 0; i < 4; i++)
      check($sformatf("skew_vote%0d", i), (i < got.size()) ? got[i] : 11'h7FF, exp2[i]);
    check("skew_no_dup", m.tvalid, 1'b0);
    check("mismatch_set", tlast_mismatch, 1'b1);
    check("skew_vote_count", vote_count, 32'd11);
    check("skew_disagree", disagree_count, 32'd7);

    // Output stalled 20 cycles while all inputs stream 8 samples
    fill(40);
    lab[1][2] = 8'd50;
    lab[1][5] = 8'd55; lab[2][5] = 8'd65;
    exp3 = '{11'h328, 11'h329, 11'h22A, 11'h32B, 11'h32C, 11'h141, 11'h32E, 11'h32F};
    m_tready = 1'b0;
    fork
      drive(0, 8, 0);
      drive(1, 8, 0);
      drive(2, 8, 0);
      begin
        repeat (5) @(negedge clk);
        check("stall_valid", m.tvalid, 1'b1);
        check("stall_data_early", m.tdata, 32'h328);
        repeat (15) @(negedge clk);
        check("stall_data_late", m.tdata, 32'h328);
        check("stall_tready_low", {rdy[0], rdy[1], rdy[2]}, 3'b000);
        m_tready = 1'b1;
        collect(8, 40);
      end
    join
    for (int i = 0; i < 8; i++)
      check($sformatf("stall_vote%0d", i), (i < got.size()) ? got[i] : 11'h7FF, exp3[i]);
    check("stall_one_per_cycle", (got.size() == 8) ? 64'(got_t[7] - got_t[0]) : 64'hFFFF, 64'd7);
    check("stall_no_dup", m.tvalid, 1'b0);
    check("stall_vote_count", vote_count, 32'd19);
    check("stall_disagree", disagree_count, 32'd9);
    check("mismatch_sticky", tlast_mismatch, 1'b1);

    // Reset with queued samples and a pending output beat
    fill(70);
    m_tready = 1'b0;
    fork
      drive(0, 4, 0);
      drive(1, 4, 0);
      drive(2, 4, 0);
    join
    @(negedge clk);
    check("pre_rst_valid", m.tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m.tvalid, 1'b0);
    check("mid_rst_tdata", m.tdata, 32'h0);
    check("mid_rst_tlast_tkeep", {m.tlast, m.tkeep}, 5'h0);
    check("mid_rst_tready", {rdy[0], rdy[1], rdy[2]}, 3'b000);
    check("mid_rst_mismatch", tlast_mismatch, 1'b0);
    check("mid_rst_counts", {vote_count, disagree_count}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (m.tvalid) stale++;
    end
    check("post_rst_no_stale", 64'(stale), 64'd0);
    check("post_rst_counts", {vote_count, disagree_count}, 64'h0);
    check("post_rst_tready", {rdy[0], rdy[1], rdy[2]}, 3'b111);
    lab[0][0] = 8'd7; lab[1][0] = 8'd7; lab[2][0] = 8'd2;
    fork
      drive(0, 1, 0);
      drive(1, 1, 0);
      drive(2, 1, 0);
      collect(1, 10);
    join
    check("post_rst_vote", (got.size() > 0) ? got[0] : 11'h7FF, 11'h207);
    @(negedge clk);
    check("post_rst_vote_count", vote_count, 32'd1);
    check("post_rst_disagree", disagree_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
